// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing source. Generates signed scan coordinates
//            (negative in blanking, 0..RES-1 in the active area), a one-clock
//            frame strobe with a frame counter, and the registered
//            RGB/data-enable/sync bundle for a TMDS encoder.
//            Defaults give 1280x720@60 (CEA-861, 74.25 MHz pixel clock).
// Ports    : pixel_clk  - pixel clock
//            rst        - asynchronous reset, active-high
//            hpos/vpos  - signed 12-bit scan position (registered)
//            fsync      - one-clock strobe at the start of each frame
//            pixel_in   - RGB for the current hpos/vpos ([2]=R,[1]=G,[0]=B)
//            rgb_out    - registered RGB, zero outside the active area
//            de         - data enable, aligned with rgb_out
//            hsync      - horizontal sync, aligned with rgb_out
//            vsync      - vertical sync, aligned with rgb_out
//            frame_cnt  - frames completed, wraps at 16 bits
//            pat_en     - colour-bar test pattern select
// Options  : VTG_TESTPAT_EN - when defined, pat_en = 1 replaces pixel_in
//            with eight vertical colour bars. When undefined pat_en is
//            ignored and no pattern logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int HRES     = 1280,
  parameter int HFP      = 110,
  parameter int HSW      = 40,
  parameter int HBP      = 220,
  parameter int VRES     = 720,
  parameter int VFP      = 5,
  parameter int VSW      = 5,
  parameter int VBP      = 20,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               fsync,
  input  logic [2:0][7:0]    pixel_in,
  output logic [2:0][7:0]    rgb_out,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [15:0]        frame_cnt,
  input  logic               pat_en
);

  localparam int HBLANK = HFP + HSW + HBP;
  localparam int VBLANK = VFP + VSW + VBP;

  // Coordinates must fit a 12-bit signed range: -2048 .. 2047.
  generate
    if (HBLANK > 2048 || HRES > 2047 || HRES < 1) begin : g_bad_h
      $error("video_timing_gen: horizontal timing out of 12-bit signed range");
    end
    if (VBLANK > 2048 || VRES > 2047 || VRES < 1) begin : g_bad_v
      $error("video_timing_gen: vertical timing out of 12-bit signed range");
    end
  endgenerate

  // Blanking starts at -BLANK with the front porch, then sync, then back porch.
  localparam logic signed [11:0] H_FIRST  = 12'(-HBLANK);
  localparam logic signed [11:0] H_LAST   = 12'(HRES - 1);
  localparam logic signed [11:0] HS_FIRST = 12'(HFP - HBLANK);
  localparam logic signed [11:0] HS_LAST  = 12'(HFP + HSW - 1 - HBLANK);
  localparam logic signed [11:0] V_FIRST  = 12'(-VBLANK);
  localparam logic signed [11:0] V_LAST   = 12'(VRES - 1);
  localparam logic signed [11:0] VS_FIRST = 12'(VFP - VBLANK);
  localparam logic signed [11:0] VS_LAST  = 12'(VFP + VSW - 1 - VBLANK);

  logic            h_wrap;
  logic            v_wrap;
  logic            de_raw;
  logic            hs_raw;
  logic            vs_raw;
  logic [2:0][7:0] pix_src;

  assign h_wrap = (hpos == H_LAST);
  assign v_wrap = (vpos == V_LAST);

  // Scan counters
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hpos <= H_FIRST;
      vpos <= V_FIRST;
    end else if (h_wrap) begin
      hpos <= H_FIRST;
      vpos <= v_wrap ? V_FIRST : vpos + 12'sd1;
    end else begin
      hpos <= hpos + 12'sd1;
    end
  end

  // Active area is exactly where both coordinates are non-negative,
  // so the sign bits are sufficient.
  assign de_raw = !hpos[11] && !vpos[11];
  assign hs_raw = (hpos >= HS_FIRST) && (hpos <= HS_LAST);
  // Progressive scan: vsync covers whole lines, no half-line offset.
  assign vs_raw = (vpos >= VS_FIRST) && (vpos <= VS_LAST);

  // Frame strobe lands on the first blanking pixel of the new frame, so
  // objects that update on fsync do so inside vertical blanking.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      fsync     <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      fsync <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef VTG_TESTPAT_EN
  localparam int          BAR_W_I = (HRES / 8 > 0) ? HRES / 8 : 1;
  localparam logic [10:0] BAR_W   = 11'(BAR_W_I);

  logic [10:0]     bar_q;
  logic [2:0]      bar;
  logic [2:0][7:0] pat_rgb;

  // The bar index is only meaningful in the active area (hpos >= 0);
  // elsewhere the output stage forces black anyway. Clamp covers
  // widths that are not a multiple of eight.
  always_comb begin
    bar_q   = hpos[10:0] / BAR_W;
    bar     = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    pat_rgb = '0;
    case (bar)
      3'd0:    pat_rgb = 24'hFFFFFF;
      3'd1:    pat_rgb = 24'hFFFF00;
      3'd2:    pat_rgb = 24'h00FFFF;
      3'd3:    pat_rgb = 24'h00FF00;
      3'd4:    pat_rgb = 24'hFF00FF;
      3'd5:    pat_rgb = 24'hFF0000;
      3'd6:    pat_rgb = 24'h0000FF;
      default: pat_rgb = 24'h000000;
    endcase
  end

  assign pix_src = pat_en ? pat_rgb : pixel_in;
`else
  logic unused_pat_en;
  assign unused_pat_en = pat_en;
  assign pix_src       = pixel_in;
`endif

  // Output stage: one clock behind hpos/vpos, black outside the active area.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      rgb_out <= '0;
      de      <= 1'b0;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else begin
      rgb_out <= de_raw ? pix_src : '0;
      de      <= de_raw;
      hsync   <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench for video_timing_gen on a reduced raster
//            (16x6 active, 25 clocks/line, 11 lines/frame). A reference model
//            derives every output from the number of clocks since reset
//            release; directed phases pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int HRES   = 16;
  localparam int HFP    = 3;
  localparam int HSW    = 2;
  localparam int HBP    = 4;
  localparam int VRES   = 6;
  localparam int VFP    = 1;
  localparam int VSW    = 2;
  localparam int VBP    = 2;
  localparam bit POL    = 1'b0;
  localparam int HBLANK = HFP + HSW + HBP;   // 9
  localparam int VBLANK = VFP + VSW + VBP;   // 5
  localparam int LINE   = HRES + HBLANK;     // 25
  localparam int FRAME  = VRES + VBLANK;     // 11
  localparam int FTOT   = LINE * FRAME;      // 275

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic               pixel_clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               fsync;
  logic [2:0][7:0]    pixel_in = '0;
  logic [2:0][7:0]    rgb_out;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic [15:0]        frame_cnt;
  logic               pat_en = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  int          t = 0;          // clock edges since reset release
  logic [23:0] last_pix = '0;  // pixel_in captured at the latest edge
  logic        last_pat = 1'b0;

  video_timing_gen #(
    .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .SYNC_POL(POL)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .hpos(hpos),
    .vpos(vpos),
    .fsync(fsync),
    .pixel_in(pixel_in),
    .rgb_out(rgb_out),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_cnt(frame_cnt),
    .pat_en(pat_en)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic wait_fsync(output int n);
    n = -1;
    for (int i = 1; i <= 2 * FTOT; i++) begin
      @(negedge pixel_clk);
      if (fsync === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference model state: edge count and the inputs seen at the edge.
  initial forever begin
    @(posedge pixel_clk or posedge rst);
    if (rst) begin
      t = 0;
    end else begin
      last_pix = pixel_in;
      last_pat = pat_en;
      t++;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    int          h, v, ph, pv;
    logic        e_de, e_hs, e_vs, pat_on;
    logic [23:0] e_rgb;
    @(negedge pixel_clk);
    if (!rst) begin
      h = t % LINE;
      v = (t / LINE) % FRAME;
      chk("hpos", hpos, h - HBLANK);
      chk("vpos", vpos, v - VBLANK);
      chk("fsync", fsync, (t > 0) && (t % FTOT == 0));
      chk("frame_cnt", frame_cnt, (t / FTOT) % 65536);
      if (t == 0) begin
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0;
      end else begin
        ph   = (t - 1) % LINE;
        pv   = ((t - 1) / LINE) % FRAME;
        e_de = (ph >= HBLANK) && (pv >= VBLANK);
        e_hs = (ph >= HFP) && (ph < HFP + HSW);
        e_vs = (pv >= VFP) && (pv < VFP + VSW);
`ifdef VTG_TESTPAT_EN
        pat_on = last_pat;
`else
        pat_on = 1'b0;
`endif
        if (!e_de)       e_rgb = '0;
        else if (pat_on) e_rgb = BARS[(ph - HBLANK) / (HRES / 8)];
        else             e_rgb = last_pix;
      end
      chk("de", de, e_de);
      chk("hsync", hsync, e_hs ? POL : !POL);
      chk("vsync", vsync, e_vs ? POL : !POL);
      chk("rgb_out", rgb_out, e_rgb);
    end
  end

  // Stimulus: inputs change 2 time units after each rising edge.
  initial forever begin
    @(posedge pixel_clk);
    #2;
    case (mode)
      0: begin
        pixel_in = 24'($urandom);
        pat_en   = 1'($urandom_range(0, 1));
      end
      1: begin
        pat_en   = 1'b0;
        pixel_in = (hpos == 0 && vpos == 0) ? 24'h00FF90 : 24'h000000;
      end
      2: begin
        pat_en   = 1'b0;
        pixel_in = 24'hFFFFFF;
      end
      default: begin
        pat_en   = 1'b1;
        pixel_in = 24'($urandom);
      end
    endcase
  end

  initial begin
    int n;
    int cnt_de, cnt_hs, cnt_vs, nz, nz_h, last_de_i, viol_blank, viol_act, found;
    logic [23:0] nz_val;
    logic nz_de, prev_hs, gap_done;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_hpos", hpos, -9);
    chk("rst_vpos", vpos, -5);
    chk("rst_fsync", fsync, 0);
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    #9 rst = 1'b0;   // t=12, between edges

    @(posedge pixel_clk);
    #1;
    chk("first_step_hpos", hpos, -8);
    chk("first_step_vpos", vpos, -5);

    // Frame period, counter and strobe width
    wait_fsync(n);
    chk("first_fsync_delay", n, 275);
    chk("frame_cnt_1", frame_cnt, 1);
    wait_fsync(n);
    chk("fsync_period", n, 275);
    chk("frame_cnt_2", frame_cnt, 2);
    @(negedge pixel_clk);
    chk("fsync_width", fsync, 0);

    // Single coloured pixel at (0,0)
    mode = 1;
    repeat (2) @(negedge pixel_clk);
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; nz = 0; nz_h = -100; nz_val = '0; nz_de = 1'b0;
    last_de_i = -1000; prev_hs = hsync; gap_done = 1'b0;
    for (int i = 0; i < FTOT; i++) begin
      @(negedge pixel_clk);
      if (de) begin
        cnt_de++;
        last_de_i = i;
      end
      if (hsync == POL) cnt_hs++;
      if (vsync == POL) cnt_vs++;
      if (hsync == POL && prev_hs != POL && !gap_done && (i - last_de_i) < LINE) begin
        chk("hsync_after_de", i - last_de_i, 4);
        gap_done = 1'b1;
      end
      prev_hs = hsync;
      if (rgb_out != '0) begin
        nz++;
        nz_val = rgb_out;
        nz_de  = de;
        nz_h   = hpos;
      end
    end
    chk("de_clocks_per_frame", cnt_de, 96);
    chk("hsync_clocks_per_frame", cnt_hs, 22);
    chk("vsync_clocks_per_frame", cnt_vs, 50);
    chk("hsync_edge_seen", gap_done, 1);
    chk("nonzero_pixels", nz, 1);
    chk("pixel_value", nz_val, 24'h00FF90);
    chk("pixel_de", nz_de, 1);
    chk("pixel_hpos_lag", nz_h, 1);

    // Constant white input must stay black during blanking
    mode = 2;
    repeat (2) @(negedge pixel_clk);
    viol_blank = 0; viol_act = 0;
    for (int i = 0; i < FTOT; i++) begin
      @(negedge pixel_clk);
      if (!de && rgb_out != '0) viol_blank++;
      if (de && rgb_out != 24'hFFFFFF) viol_act++;
    end
    chk("blank_is_black", viol_blank, 0);
    chk("active_is_white", viol_act, 0);

    // Random traffic, checked by the model every cycle
    mode = 0;
    repeat (3 * FTOT) @(negedge pixel_clk);

    // Asynchronous reset mid-frame, mid-clock
    found = 0;
    for (int i = 0; i < 2 * FTOT; i++) begin
      @(negedge pixel_clk);
      if (hpos == 5 && vpos == 3) begin
        found = 1;
        break;
      end
    end
    chk("reach_mid_frame", found, 1);
    @(posedge pixel_clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_hpos", hpos, -9);
    chk("async_rst_vpos", vpos, -5);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("async_rst_de", de, 0);
    chk("async_rst_rgb", rgb_out, 0);
    chk("async_rst_hsync", hsync, 1);
    #3 rst = 1'b0;
    wait_fsync(n);
    chk("fsync_after_rst", n, 275);
    chk("frame_cnt_after_rst", frame_cnt, 1);

`ifdef VTG_TESTPAT_EN
    // Colour-bar boundaries on the first active line (bars are 2 px wide)
    mode = 3;
    repeat (2) @(negedge pixel_clk);
    found = 0;
    for (int i = 0; i < FTOT + 2; i++) begin
      @(negedge pixel_clk);
      if (hpos == 2 && vpos == 0) begin
        chk("bar0_last_px", rgb_out, 24'hFFFFFF);
        found++;
      end
      if (hpos == 3 && vpos == 0) begin
        chk("bar1_first_px", rgb_out, 24'hFFFF00);
        found++;
      end
      if (hpos == -9 && vpos == 1) begin
        chk("bar7_last_px", rgb_out, 24'h000000);
        chk("bar7_de", de, 1);
        found++;
      end
    end
    chk("bar_points_seen", found, 3);
    mode = 0;
    repeat (FTOT) @(negedge pixel_clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster source that generates the scan position and frame strobe consumed by on-screen objects (ball, paddles), and the sync and data-enable timing for the HDMI/TMDS encoder.
- Drives signed hpos/vpos, negative during blanking and 0..RES-1 in the active area, plus a one-cycle fsync per frame.
- Takes back the composited RGB pixel for the current position and re-registers it aligned with hsync/vsync/de.
- Defaults are 1280x720@60 (CEA-861, 74.25 MHz pixel clock).

Parameters:
- HRES, 1280, active pixels per line
- HFP, 110, horizontal front porch (clocks)
- HSW, 40, hsync width
- HBP, 220, horizontal back porch
- VRES, 720, active lines per frame
- VFP, 5, vertical front porch (lines)
- VSW, 5, vsync width
- VBP, 20, vertical back porch
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- hpos  out  12 signed  current horizontal position
- vpos  out  12 signed  current vertical position
- fsync  out  1  one-cycle frame strobe
- pixel_in  in  8 x [0:2]  RGB for current hpos/vpos; [2]=R, [1]=G, [0]=B; combinational from objects
- rgb_out  out  8 x [0:2]  registered RGB to encoder
- de  out  1  data enable, aligned with rgb_out
- hsync  out  1  aligned with rgb_out
- vsync  out  1  aligned with rgb_out
- frame_cnt  out  16  frames completed, wraps
- pat_en  in  1  test-pattern select (see Optional Feature)

Behaviour:
- Derived constants: HBLANK = HFP+HSW+HBP = 370; VBLANK = VFP+VSW+VBP = 30. Line total 1650 clocks; frame total 750 lines.
- Legal parameters: HBLANK <= 2048, HRES <= 2047, and likewise for V. Outside this range is an elaboration error.
- Counters are registered, one step per clock:
  - hpos runs -HBLANK .. HRES-1, then wraps to -HBLANK.
  - vpos increments when hpos wraps; runs -VBLANK .. VRES-1, then wraps to -VBLANK.
- Line layout (hpos):
  - front porch: -370..-261
  - sync: -260..-221
  - back porch: -220..-1
  - active: 0..1279
- Frame layout (vpos):
  - front porch: -30..-26
  - sync: -25..-21
  - back porch: -20..-1
  - active: 0..719
- Raw (pre-register) timing:
  - h_act = hpos >= 0; v_act = vpos >= 0; de_raw = h_act & v_act.
  - hs_raw asserted while hpos is in the hsync range.
  - vs_raw asserted over every clock of lines whose vpos is in the vsync range (progressive; no half-line offset).
  - Sync output level = SYNC_POL when asserted, ~SYNC_POL otherwise.
- fsync:
  - Registered; high for exactly one clock on the cycle after hpos = HRES-1 and vpos = VRES-1, i.e. while hpos = -HBLANK, vpos = -VBLANK.
  - Objects therefore update inside vertical blanking.
  - frame_cnt increments on the same clock fsync is high; wraps 0xFFFF -> 0.
- Output stage (latency 1):
  - On each clock, rgb_out <= de_raw ? pixel_in : 0; de <= de_raw; hsync/vsync <= sync levels.
  - rgb_out/de/hsync/vsync lag hpos/vpos by exactly one clock.
  - rgb_out is 0 whenever de is 0.
- Reset (async assert, sync release):
  - hpos = -HBLANK, vpos = -VBLANK.
  - fsync = 0, de = 0, rgb_out = 0, frame_cnt = 0, hsync = vsync = ~SYNC_POL.
  - First clock after release: hpos -> -HBLANK+1. No fsync until the first full frame ends.
- Reset mid-frame: all state returns to the reset values immediately. No partial fsync is issued.

Optional Feature:
- VTG_TESTPAT_EN defined, pat_en = 1:
  - pixel_in is ignored.
  - Active area shows 8 vertical colour bars, each HRES/8 = 160 px wide, bar index = hpos/160.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Same 1-clock latency and blanking rules as the normal path.
  - pat_en is sampled per clock, so a switch takes effect on the next pixel.
- VTG_TESTPAT_EN defined, pat_en = 0: normal pixel_in path.
- VTG_TESTPAT_EN undefined: pat_en port exists but is ignored; no pattern logic is synthesised.

Test Plan:
- Reset, then run 2 frames, counting clocks between fsync pulses -> exactly 1,237,500 (1650x750); frame_cnt = 1 then 2; fsync width is 1 clock.
- Per line -> hsync high for exactly 40 clocks, beginning 111 clocks after de falls; de high for 1280 clocks per active line over 720 lines; vsync spans 5 lines (8250 clocks).
- Drive pixel_in = 24'h00FF90 only when hpos = 0 and vpos = 0 -> rgb_out = 00FF90 with de = 1 exactly one clock later; all other active pixels are 0.
- Hold pixel_in = FFFFFF constant -> rgb_out = 0 whenever de = 0; no nonzero colour during blanking.
- Assert rst at hpos = 500, vpos = 300, asynchronously and mid-clock -> outputs take reset values before the next edge; hpos = -370, vpos = -30, frame_cnt = 0; next fsync comes 1,237,500 clocks after release.
- With VTG_TESTPAT_EN defined and pat_en = 1 -> on vpos = 0, rgb_out at hpos 159 = FFFFFF, at hpos 160 = FFFF00, at hpos 1279 = 000000; preset frame_cnt wraps 0xFFFF -> 0 at the next fsync.
